pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the pipeline, complementing the operand-forwarding

---
 rtl/pipe_stall_ctrl.sv | 138 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer: load-use holds, data-memory wait freeze and redirect flush.
// Controls are Mealy, so they take effect in the same cycle as the inputs; no valid/ready handshake.
module pipe_stall_ctrl #(
  parameter int LU_STALL_CYC = 1,
  parameter int MEM_TIMEOUT  = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IDU_valid,
  input  logic [4:0]       IDU_rs1,
  input  logic [4:0]       IDU_rs2,
  input  logic             IDU_rs1_used,
  input  logic             IDU_rs2_used,
  input  logic             EXU_valid,
  input  logic [4:0]       EXU_rd,
  input  logic             EXU_R_Wen,
  input  logic             EXU_mem_ren,
  input  logic             EXU_redirect,
  input  logic             MEM_req,
  input  logic             MEM_ack,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             ID_EX_bubble,
  output logic             EX_MEM_stall,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                WW      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WW-1:0]     TMO     = WW'(MEM_TIMEOUT);
  localparam logic [1:0]        LU_INIT = 2'(LU_STALL_CYC - 1);

  typedef enum logic [1:0] {S_RUN, S_LU_STALL, S_MEM_WAIT} state_t;

  state_t           state_q, state_nx, ret_q, ret_nx;
  logic [1:0]       lu_cnt_q, lu_cnt_nx;
  logic [WW-1:0]    wait_cnt_q, wait_cnt_nx;
  logic             timeout_q, timeout_nx;
  logic [CNT_W-1:0] cnt_q;

  logic lu_hit, mem_busy;
  logic freeze_c, lu_ctl_c, flush_c;

  assign lu_hit = IDU_valid & EXU_valid & EXU_mem_ren & EXU_R_Wen & (EXU_rd != 5'd0) &
                  ((IDU_rs1_used & (IDU_rs1 == EXU_rd)) | (IDU_rs2_used & (IDU_rs2 == EXU_rd)));
  assign mem_busy = MEM_req & ~MEM_ack;

  always_comb begin
    freeze_c    = 1'b0;
    lu_ctl_c    = 1'b0;
    flush_c     = 1'b0;
    state_nx    = state_q;
    ret_nx      = ret_q;
    lu_cnt_nx   = lu_cnt_q;
    wait_cnt_nx = wait_cnt_q;
    timeout_nx  = timeout_q;
    case (state_q)
      S_RUN: begin
        if (mem_busy) begin
          freeze_c    = 1'b1;
          state_nx    = S_MEM_WAIT;
          ret_nx      = S_RUN;
          wait_cnt_nx = WW'(1);
        end else if (EXU_redirect) begin
          flush_c = 1'b1;
        end else if (lu_hit) begin
          lu_ctl_c = 1'b1;
          // A single-cycle hold needs no state: EXU carries the bubble next cycle.
          if (LU_STALL_CYC > 1) begin
            state_nx  = S_LU_STALL;
            lu_cnt_nx = LU_INIT;
          end
        end
      end
      S_LU_STALL: begin
        if (mem_busy) begin
          freeze_c    = 1'b1;
          state_nx    = S_MEM_WAIT;
          ret_nx      = S_LU_STALL;
          wait_cnt_nx = WW'(1);
        end else if (EXU_redirect) begin
          flush_c   = 1'b1;
          lu_cnt_nx = 2'd0;
          state_nx  = S_RUN;
        end else begin
          lu_ctl_c  = 1'b1;
          lu_cnt_nx = lu_cnt_q - 2'd1;
          if (lu_cnt_q == 2'd1) state_nx = S_RUN;
        end
      end
      S_MEM_WAIT: begin
        if (mem_busy) begin
          freeze_c = 1'b1;
          if (wait_cnt_q < TMO) begin
            wait_cnt_nx = wait_cnt_q + WW'(1);
            if (wait_cnt_q == TMO - WW'(1)) timeout_nx = 1'b1;
          end
        end else begin
          wait_cnt_nx = '0;
          state_nx    = ret_q;
        end
      end
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      ret_q      <= S_RUN;
      lu_cnt_q   <= 2'd0;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_nx;
      ret_q      <= ret_nx;
      lu_cnt_q   <= lu_cnt_nx;
      wait_cnt_q <= wait_cnt_nx;
      timeout_q  <= timeout_nx;
      if ((freeze_c | lu_ctl_c) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Gate with rst so the combinational controls drop the moment reset is asserted.
  assign pc_stall     = (freeze_c | lu_ctl_c) & ~rst;
  assign IF_ID_stall  = (freeze_c | lu_ctl_c) & ~rst;
  assign IF_ID_flush  = flush_c & ~rst;
  assign ID_EX_stall  = freeze_c & ~rst;
  assign ID_EX_bubble = (flush_c | lu_ctl_c) & ~rst;
  assign EX_MEM_stall = freeze_c & ~rst;
  assign mem_timeout  = timeout_q;
  assign stall_count  = cnt_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: dut a (LU=3, TMO=4, CNT_W=4) and dut b (defaults) share stimulus.
module tb_pipe_stall_ctrl;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] FRZ  = 6'b110101;
  localparam logic [5:0] LU   = 6'b110010;
  localparam logic [5:0] RD   = 6'b001010;

  logic clk, rst;
  logic IDU_valid, IDU_rs1_used, IDU_rs2_used;
  logic [4:0] IDU_rs1, IDU_rs2, EXU_rd;
  logic EXU_valid, EXU_R_Wen, EXU_mem_ren, EXU_redirect, MEM_req, MEM_ack;

  logic a_pc, a_ifs, a_iff, a_ies, a_ieb, a_ems, a_tmo;
  logic b_pc, b_ifs, b_iff, b_ies, b_ieb, b_ems, b_tmo;
  logic [3:0]  a_cnt;
  logic [31:0] b_cnt;
  logic [5:0]  a_ctl, b_ctl;

  int n_cmp = 0;
  int n_err = 0;

  assign a_ctl = {a_pc, a_ifs, a_iff, a_ies, a_ieb, a_ems};
  assign b_ctl = {b_pc, b_ifs, b_iff, b_ies, b_ieb, b_ems};

  pipe_stall_ctrl #(.LU_STALL_CYC(3), .MEM_TIMEOUT(4), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst(rst),
    .IDU_valid(IDU_valid), .IDU_rs1(IDU_rs1), .IDU_rs2(IDU_rs2),
    .IDU_rs1_used(IDU_rs1_used), .IDU_rs2_used(IDU_rs2_used),
    .EXU_valid(EXU_valid), .EXU_rd(EXU_rd), .EXU_R_Wen(EXU_R_Wen),
    .EXU_mem_ren(EXU_mem_ren), .EXU_redirect(EXU_redirect),
    .MEM_req(MEM_req), .MEM_ack(MEM_ack),
    .pc_stall(a_pc), .IF_ID_stall(a_ifs), .IF_ID_flush(a_iff),
    .ID_EX_stall(a_ies), .ID_EX_bubble(a_ieb), .EX_MEM_stall(a_ems),
    .mem_timeout(a_tmo), .stall_count(a_cnt)
  );

  pipe_stall_ctrl u_dut_b (
    .clk(clk), .rst(rst),
    .IDU_valid(IDU_valid), .IDU_rs1(IDU_rs1), .IDU_rs2(IDU_rs2),
    .IDU_rs1_used(IDU_rs1_used), .IDU_rs2_used(IDU_rs2_used),
    .EXU_valid(EXU_valid), .EXU_rd(EXU_rd), .EXU_R_Wen(EXU_R_Wen),
    .EXU_mem_ren(EXU_mem_ren), .EXU_redirect(EXU_redirect),
    .MEM_req(MEM_req), .MEM_ack(MEM_ack),
    .pc_stall(b_pc), .IF_ID_stall(b_ifs), .IF_ID_flush(b_iff),
    .ID_EX_stall(b_ies), .ID_EX_bubble(b_ieb), .EX_MEM_stall(b_ems),
    .mem_timeout(b_tmo), .stall_count(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    IDU_valid = 0; IDU_rs1 = 0; IDU_rs2 = 0; IDU_rs1_used = 0; IDU_rs2_used = 0;
    EXU_valid = 0; EXU_rd = 0; EXU_R_Wen = 0; EXU_mem_ren = 0; EXU_redirect = 0;
    MEM_req = 0; MEM_ack = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    idle();
    tick();
    rst = 0;
  endtask

  task automatic ld_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    EXU_valid = 1; EXU_mem_ren = 1; EXU_R_Wen = 1; EXU_rd = rd;
    IDU_valid = 1; IDU_rs1 = rs1; IDU_rs1_used = u1; IDU_rs2 = rs2; IDU_rs2_used = u2;
  endtask

  initial begin
    rst = 1;
    idle();
    #2;
    chk("rst_ctl_a", a_ctl, NONE);
    chk("rst_ctl_b", b_ctl, NONE);
    chk("rst_cnt_b", b_cnt, 0);
    chk("rst_tmo_a", a_tmo, 0);
    tick(); tick();
    rst = 0;

    // Single-cycle load-use on dut b: lw x5 ; add x6,x5,x1
    ld_use(5'd5, 5'd5, 1, 5'd1, 1); #2;
    chk("lu1_hit_b", b_ctl, LU);
    chk("lu1_hit_a", a_ctl, LU);
    tick(); EXU_valid = 0; #2;
    chk("lu1_after_b", b_ctl, NONE);
    chk("lu1_cnt_b", b_cnt, 1);
    tick(); ld_use(5'd5, 5'd5, 0, 5'd1, 1); #2;
    chk("rs1_unused_b", b_ctl, NONE);
    ld_use(5'd0, 5'd0, 1, 5'd0, 1); #2;
    chk("rd_x0_b", b_ctl, NONE);

    // Three-cycle load-use on dut a
    do_reset();
    ld_use(5'd5, 5'd5, 1, 5'd0, 0); #2;
    chk("lu3_c1", a_ctl, LU);
    tick(); EXU_valid = 0; #2;
    chk("lu3_c2", a_ctl, LU);
    tick(); #2;
    chk("lu3_c3", a_ctl, LU);
    tick(); #2;
    chk("lu3_c4", a_ctl, NONE);
    chk("lu3_cnt", a_cnt, 3);

    // Redirect in second LU cycle cancels the stall
    do_reset();
    ld_use(5'd5, 5'd5, 1, 5'd0, 0); #2;
    chk("redir_c1", a_ctl, LU);
    tick(); EXU_valid = 0; EXU_redirect = 1; #2;
    chk("redir_c2", a_ctl, RD);
    tick(); EXU_redirect = 0; IDU_valid = 0; #2;
    chk("redir_c3", a_ctl, NONE);
    tick(); #2;
    chk("redir_c4", a_ctl, NONE);

    // Five-cycle memory wait on dut b, then a zero-wait access
    do_reset();
    MEM_req = 1;
    for (int i = 1; i <= 5; i++) begin
      #2; chk("mem5_frz", b_ctl, FRZ);
      tick();
    end
    MEM_ack = 1; #2;
    chk("mem5_ack", b_ctl, NONE);
    tick(); MEM_req = 0; MEM_ack = 0; #2;
    chk("mem5_cnt", b_cnt, 5);
    chk("mem5_tmo_b", b_tmo, 0);
    MEM_req = 1; MEM_ack = 1; #2;
    chk("zero_wait", b_ctl, NONE);
    tick(); MEM_req = 0; MEM_ack = 0; #2;
    chk("zero_wait_cnt", b_cnt, 5);
    chk("zero_wait_idle", b_ctl, NONE);

    // Timeout after four MEM_WAIT cycles on dut a, ack withheld for 10 freeze cycles
    do_reset();
    MEM_req = 1;
    for (int i = 1; i <= 10; i++) begin
      #2;
      chk("tmo_frz", a_ctl, FRZ);
      chk("tmo_flag", a_tmo, (i >= 5) ? 32'd1 : 32'd0);
      tick();
    end
    MEM_ack = 1; #2;
    chk("tmo_ack_ctl", a_ctl, NONE);
    chk("tmo_ack_flag", a_tmo, 1);
    chk("tmo_cnt", a_cnt, 10);
    tick(); idle(); #2;
    chk("tmo_sticky", a_tmo, 1);
    chk("tmo_idle", a_ctl, NONE);

    // Memory freeze during first LU_STALL cycle; remaining LU cycles resume after ack
    do_reset();
    ld_use(5'd7, 5'd0, 0, 5'd7, 1); #2;
    chk("lum_c1", a_ctl, LU);
    tick(); EXU_valid = 0; MEM_req = 1; #2;
    chk("lum_c2", a_ctl, FRZ);
    tick(); #2;
    chk("lum_c3", a_ctl, FRZ);
    tick(); #2;
    chk("lum_c4", a_ctl, FRZ);
    tick(); MEM_ack = 1; #2;
    chk("lum_ack", a_ctl, NONE);
    tick(); MEM_req = 0; MEM_ack = 0; #2;
    chk("lum_c6", a_ctl, LU);
    tick(); #2;
    chk("lum_c7", a_ctl, LU);
    tick(); #2;
    chk("lum_c8", a_ctl, NONE);
    chk("lum_cnt", a_cnt, 6);

    // Reset in the middle of MEM_WAIT clears outputs immediately
    do_reset();
    MEM_req = 1;
    tick(); tick(); #2;
    chk("rstm_pre", a_ctl, FRZ);
    rst = 1; #1;
    chk("rstm_ctl_a", a_ctl, NONE);
    chk("rstm_ctl_b", b_ctl, NONE);
    chk("rstm_cnt_a", a_cnt, 0);
    idle();
    tick();
    rst = 0;

    // Saturation of a 4-bit stall_count
    do_reset();
    MEM_req = 1;
    repeat (20) tick();
    MEM_ack = 1; #2;
    chk("sat_cnt_a", a_cnt, 15);
    chk("sat_cnt_b", b_cnt, 20);
    tick(); idle(); #2;
    chk("sat_hold_a", a_cnt, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
